// File: rtl/vl_seq_pkg.sv
// Shared types and helpers for the vector-length sequencer.
package vl_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int unsigned MVL_DEF = 32'd16;
    // The vector-length register comes out of reset holding the maximum length.
    localparam int unsigned RST_VL  = MVL_DEF;

    // Ceiling log2.
    function automatic int unsigned log2(input int unsigned n);
        int unsigned r;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

    function automatic int unsigned bitwidth(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : log2(n);
    endfunction

endpackage

// File: rtl/vl_seq_if.sv
// Element beat stream from the sequencer to the lane datapath.
interface vl_seq_if #(
    parameter int unsigned IW   = 4,
    parameter int unsigned TAGW = 8
) ();
    logic            el_valid;
    logic            el_ready;
    logic [IW-1:0]   el_idx;
    logic [TAGW-1:0] el_tag;
    logic            el_last;
    logic            el_active;

    modport master (
        output el_valid, el_idx, el_tag, el_last, el_active,
        input  el_ready
    );

    modport slave (
        input  el_valid, el_idx, el_tag, el_last, el_active,
        output el_ready
    );
endinterface

// File: rtl/vl_elem_counter.sv
// Element index counter with synchronous clear-load, advance enable and
// terminal-count compare (last = idx is the final element of term).
module vl_elem_counter #(
    parameter int unsigned IW  = 4,
    parameter int unsigned VLW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           en,
    input  logic [VLW-1:0] term,
    output logic [IW-1:0]  idx,
    output logic           last
);
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;

    // Next index: clear on load, advance on enable, else hold.
    always_comb begin
        idx_d = idx_q;
        if (load) begin
            idx_d = {IW{1'b0}};
        end else if (en) begin
            idx_d = idx_q + IW'(1);
        end else begin
            idx_d = idx_q;
        end
    end

    // Index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= {IW{1'b0}};
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx  = idx_q;
    assign last = (VLW'(idx_q) == (term - VLW'(1)));
endmodule

// File: rtl/vl_seq_ctrl.sv
// Vector-length controller: vsetvl grant (vl = min(AVL, MVL)) and per-element
// sequencing of operations. Optional macro VL_SEQ_TAIL_EN always walks MVL beats.
module vl_seq_ctrl
    import vl_seq_pkg::*;
#(
    parameter int unsigned MVL  = 16,
    parameter int unsigned VLW  = bitwidth(MVL) + 1,
    parameter int unsigned IW   = bitwidth(MVL),
    parameter int unsigned TAGW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [31:0]     cfg_avl,
    output logic            rsp_valid,
    output logic [VLW-1:0]  rsp_vl,
    output logic            vl_we,
    output logic [VLW-1:0]  vl_wdata,
    input  logic [VLW-1:0]  vl_q,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [TAGW-1:0] op_tag,
    vl_seq_if.master        el,
    output logic            op_done,
    output logic            busy
);
    state_e          state_q, state_d;
    logic [VLW-1:0]  avl_clip_q, avl_clip_d;
    logic [VLW-1:0]  vl_run_q, vl_run_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic            op_done_q, op_done_d;

    logic            cnt_load, cnt_en, cnt_last;
    logic [IW-1:0]   cnt_idx;
    logic [VLW-1:0]  term;
    logic            start_empty;
    logic [VLW-1:0]  avl_clip_s;

    assign avl_clip_s = (cfg_avl >= 32'(MVL)) ? VLW'(MVL) : cfg_avl[VLW-1:0];

`ifdef VL_SEQ_TAIL_EN
    assign term         = VLW'(MVL);
    assign start_empty  = 1'b0;
    assign el.el_active = (VLW'(cnt_idx) < vl_run_q);
`else
    // vl_q is checked at accept time, before vl_run has captured it.
    assign term         = vl_run_q;
    assign start_empty  = (vl_q == {VLW{1'b0}});
    assign el.el_active = 1'b1;
`endif

    vl_elem_counter #(.IW(IW), .VLW(VLW)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (cnt_en),
        .term (term),
        .idx  (cnt_idx),
        .last (cnt_last)
    );

    // Next-state and datapath control; configuration wins over an operation.
    always_comb begin
        state_d    = state_q;
        avl_clip_d = avl_clip_q;
        vl_run_d   = vl_run_q;
        tag_d      = tag_q;
        op_done_d  = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    state_d    = CFG;
                    avl_clip_d = avl_clip_s;
                end else if (op_valid) begin
                    vl_run_d = vl_q;
                    tag_d    = op_tag;
                    cnt_load = 1'b1;
                    if (start_empty) begin
                        op_done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CFG: begin
                state_d = IDLE;
            end
            RUN: begin
                if (el.el_ready) begin
                    if (cnt_last) begin
                        state_d   = IDLE;
                        op_done_d = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            avl_clip_q <= {VLW{1'b0}};
            vl_run_q   <= {VLW{1'b0}};
            tag_q      <= {TAGW{1'b0}};
            op_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            avl_clip_q <= avl_clip_d;
            vl_run_q   <= vl_run_d;
            tag_q      <= tag_d;
            op_done_q  <= op_done_d;
        end
    end

    assign cfg_ready   = (state_q == IDLE);
    assign op_ready    = (state_q == IDLE) && !cfg_valid;
    assign rsp_valid   = (state_q == CFG);
    assign rsp_vl      = avl_clip_q;
    assign vl_we       = (state_q == CFG);
    assign vl_wdata    = avl_clip_q;
    assign el.el_valid = (state_q == RUN);
    assign el.el_idx   = cnt_idx;
    assign el.el_tag   = tag_q;
    assign el.el_last  = (state_q == RUN) && cnt_last;
    assign op_done     = op_done_q;
    assign busy        = (state_q != IDLE);
endmodule
